// File: rtl/pipelined_subtractor_if.sv
// Handshake and operand/result bundle for the pipelined subtractor.
// The master side drives operands and out_ready; the slave side returns results.
interface pipelined_subtractor_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        Bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Diff;
    logic        Bout;
    logic        Ovf;

    modport master (
        output in_valid,
        output A,
        output B,
        output Bin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  Diff,
        input  Bout,
        input  Ovf
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  Bin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output Diff,
        output Bout,
        output Ovf
    );
endinterface

// File: rtl/pipelined_subtractor.sv
// 32-bit A - B - Bin computed as A + ~B + ~Bin, one byte per stage over four stages,
// behind an operand capture register; the whole pipeline freezes on output backpressure.
module pipelined_subtractor (
    input  logic                  clk,
    input  logic                  rst,
    pipelined_subtractor_if.slave bus
);
    typedef struct packed {
        logic        v;
        logic [31:0] a;
        logic [31:0] nb;
        logic [31:0] d;
        logic        c;
    } stage_t;

    // 8-bit carry lookahead: every carry is a flat OR of generate/propagate terms.
    function automatic logic [8:0] cla8(input logic [7:0] a, input logic [7:0] b,
                                        input logic cin);
        logic [7:0] g;
        logic [7:0] p;
        logic [8:0] c;
        logic       term;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            term = cin;
            for (int j = 0; j <= i; j++) begin
                term = term & p[j];
            end
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                c[i+1] = c[i+1] | term;
            end
        end
        return {c[8], p ^ c[7:0]};
    endfunction

    stage_t       in_q;
    stage_t       in_d;
    stage_t [3:0] st_q;
    stage_t [3:0] st_d;
    logic         bout_q;
    logic         bout_d;
    logic         ovf_q;
    logic         ovf_d;
    logic         stall;
    logic         accept;
    stage_t       src;
    logic [8:0]   slice;

    assign stall        = st_q[3].v && !bus.out_ready;
    assign bus.in_ready = !stall && !rst;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        in_d   = in_q;
        st_d   = st_q;
        bout_d = bout_q;
        ovf_d  = ovf_q;
        src    = in_q;
        slice  = '0;
        if (!stall) begin
            // Bubbles load zeros so idle outputs stay deterministic.
            in_d = '0;
            if (accept) begin
                in_d.v  = 1'b1;
                in_d.a  = bus.A;
                in_d.nb = ~bus.B;
                in_d.c  = ~bus.Bin;
            end
            for (int k = 0; k < 4; k++) begin
                slice               = cla8(src.a[8*k +: 8], src.nb[8*k +: 8], src.c);
                st_d[k]             = src;
                st_d[k].d[8*k +: 8] = slice[7:0];
                st_d[k].c           = slice[8];
                src                 = st_q[k];
            end
            bout_d = st_d[3].v && !st_d[3].c;
            ovf_d  = st_d[3].v && (st_d[3].a[31] == st_d[3].nb[31]) &&
                     (st_d[3].d[31] != st_d[3].a[31]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q   <= '0;
            st_q   <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            in_q   <= in_d;
            st_q   <= st_d;
            bout_q <= bout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.out_valid = st_q[3].v;
    assign bus.Diff      = st_q[3].d;
    assign bus.Bout      = bout_q;
    assign bus.Ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_subtractor.sv
// Directed vector table, backpressure and reset sequences, and a random soak,
// all cross-checked by an always-on in-order scoreboard.
module tb_pipelined_subtractor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_subtractor_if bif ();

    pipelined_subtractor dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] d;
        logic        bo;
        logic        ov;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] d;
        logic        bo;
        logic        ov;
    } vec_t;

    res_t exp_q[$];
    logic mon_en = 1'b0;

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic bin);
        logic [32:0] full;
        res_t r;
        full = {1'b0, a} - {1'b0, b} - {32'd0, bin};
        r.d  = full[31:0];
        r.bo = full[32];
        r.ov = (a[31] != b[31]) && (r.d[31] != a[31]);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: transfers are decided by the values present at the negative edge.
    initial begin : monitor
        logic prev_stall;
        logic prev_rst;
        logic prev_v;
        res_t prev_out;
        res_t r;
        prev_stall = 1'b0;
        prev_rst   = 1'b1;
        prev_v     = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (prev_stall && !prev_rst) begin
                    check("hold_valid", 32'(bif.out_valid), 32'(prev_v));
                    check("hold_diff", bif.Diff, prev_out.d);
                    check("hold_flags", {30'd0, bif.Bout, bif.Ovf}, {30'd0, prev_out.bo, prev_out.ov});
                end
                check("in_ready_rule", 32'(bif.in_ready),
                      32'(!rst && !(bif.out_valid && !bif.out_ready)));
                if (rst) begin
                    exp_q.delete();
                end else begin
                    if (bif.out_valid && bif.out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_result", 32'd1, 32'd0);
                        end else begin
                            r = exp_q.pop_front();
                            check("sb_diff", bif.Diff, r.d);
                            check("sb_flags", {30'd0, bif.Bout, bif.Ovf}, {30'd0, r.bo, r.ov});
                        end
                    end
                    if (bif.in_valid && bif.in_ready)
                        exp_q.push_back(model(bif.A, bif.B, bif.Bin));
                end
            end
            prev_stall = bif.out_valid && !bif.out_ready;
            prev_rst   = rst;
            prev_v     = bif.out_valid;
            prev_out   = '{d: bif.Diff, bo: bif.Bout, ov: bif.Ovf};
        end
    end

    // One set into an empty pipeline; the result must appear exactly after the fourth edge.
    task automatic run_vec(input vec_t v, input string tag);
        @(posedge clk); #1;
        bif.in_valid  = 1'b1;
        bif.A         = v.a;
        bif.B         = v.b;
        bif.Bin       = v.bin;
        bif.out_ready = 1'b1;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            if (e < 4) begin
                check({tag, "_early"}, 32'(bif.out_valid), 32'd0);
            end else begin
                check({tag, "_valid"}, 32'(bif.out_valid), 32'd1);
                check({tag, "_diff"}, bif.Diff, v.d);
                check({tag, "_bout"}, 32'(bif.Bout), 32'(v.bo));
                check({tag, "_ovf"}, 32'(bif.Ovf), 32'(v.ov));
            end
        end
    endtask

    vec_t vecs[12];

    initial begin : main
        int   sent;
        int   got;
        int   accepted;
        int   cycles;
        logic [31:0] held;
        vecs[0]  = '{32'd5,        32'd3,        1'b0, 32'h0000_0002, 1'b0, 1'b0};
        vecs[1]  = '{32'd0,        32'd1,        1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[2]  = '{32'd0,        32'd0,        1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[3]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[4]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
        vecs[5]  = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[6]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[7]  = '{32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0};
        vecs[8]  = '{32'h0100_0000, 32'h0000_0001, 1'b0, 32'h00FF_FFFF, 1'b0, 1'b0};
        vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[10] = '{32'h0000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
        vecs[11] = '{32'h0001_0000, 32'h0000_FFFF, 1'b1, 32'h0000_0000, 1'b0, 1'b0};

        rst           = 1'b1;
        bif.in_valid  = 1'b0;
        bif.A         = '0;
        bif.B         = '0;
        bif.Bin       = 1'b0;
        bif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bif.out_valid), 32'd0);
        check("rst_diff", bif.Diff, 32'd0);
        check("rst_flags", {30'd0, bif.Bout, bif.Ovf}, 32'd0);
        check("rst_in_ready", 32'(bif.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bif.in_ready), 32'd1);
        mon_en = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: six back-to-back sets, out_ready low in cycles 5..7.
        sent = 0;
        got  = 0;
        held = '0;
        for (int t = 0; t < 40 && got < 6; t++) begin
            @(posedge clk); #1;
            bif.in_valid  = (sent < 6);
            bif.A         = 32'(sent + 10);
            bif.B         = 32'(sent);
            bif.Bin       = 1'b0;
            bif.out_ready = !(t >= 5 && t <= 7);
            @(negedge clk);
            check($sformatf("bp_in_ready_t%0d", t), 32'(bif.in_ready),
                  32'(!(t >= 5 && t <= 7)));
            if (t == 5) begin
                check("bp_valid_at_stall", 32'(bif.out_valid), 32'd1);
                held = bif.Diff;
            end
            if (t == 6 || t == 7) check("bp_diff_held", bif.Diff, held);
            if (bif.out_valid && bif.out_ready) begin
                got++;
                check("bp_diff", bif.Diff, 32'd10);
            end
            if (bif.in_valid && bif.in_ready) sent++;
        end
        check("bp_result_count", 32'(got), 32'd6);
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        repeat (6) @(posedge clk);

        // Reset with three sets in flight.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bif.in_valid  = 1'b1;
            bif.A         = 32'(1000 + i);
            bif.B         = 32'd1;
            bif.Bin       = 1'b0;
            bif.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        check("midrst_none_out_yet", 32'(bif.out_valid), 32'd0);
        @(posedge clk); #1;
        check("midrst_out_valid", 32'(bif.out_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 32'(bif.in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("midrst_no_stale", 32'(bif.out_valid), 32'd0);
        end
        run_vec('{32'h0000_1000, 32'h0000_0001, 1'b1, 32'h0000_0FFE, 1'b0, 1'b0}, "midrst_new");

        // Random soak with random valid/ready.
        accepted = 0;
        cycles   = 0;
        while (accepted < 10000 && cycles < 60000) begin
            @(posedge clk); #1;
            bif.in_valid  = ($urandom_range(0, 9) < 7);
            bif.A         = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            bif.B         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            bif.Bin       = 1'($urandom_range(0, 1));
            bif.out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (bif.in_valid && bif.in_ready) accepted++;
            cycles++;
        end
        check("rand_accepted", 32'(accepted), 32'd10000);
        @(posedge clk); #1;
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipelined_subtractor.md
PIPELINED_SUBTRACTOR -- requirements
Module: pipelined_subtractor

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits and pipeline depth is fixed at 4 stages.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operand set on A/B/Bin is valid.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 A  input  32  signed minuend.
REQ-008 B  input  32  signed subtrahend.
REQ-009 Bin  input  1  borrow-in.
REQ-010 out_valid  output  1  Diff/Bout/Ovf are valid.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 Diff  output  32  signed difference, A - B - Bin, modulo 2^32.
REQ-013 Bout  output  1  borrow-out: 1 iff unsigned A < unsigned B + Bin.
REQ-014 Ovf  output  1  signed overflow of the subtraction.

Function
REQ-015 Arithmetic SHALL be computed as A + ~B + ~Bin; Bout SHALL equal the inverted carry-out of bit 31.
REQ-016 Ovf SHALL be 1 iff A[31] != B[31] and Diff[31] != A[31].
REQ-017 Stage k (k=0..3) SHALL compute bits [8k+7:8k] with 8-bit lookahead generate/propagate and register the slice result plus the inter-stage carry; unprocessed operand bits and already-computed slices SHALL travel alongside in stage registers.
REQ-018 An operand set SHALL be accepted on any cycle where in_valid && in_ready.
REQ-019 Latency SHALL be exactly 4 cycles: a set accepted at edge N appears with out_valid=1 after edge N+4, provided there is no stall.
REQ-020 A result SHALL transfer on any cycle where out_valid && out_ready.
REQ-021 stall = out_valid && !out_ready; while stall is high, every stage register and valid bit SHALL hold its value.
REQ-022 in_ready SHALL equal !stall, combinationally; it SHALL NOT depend on in_valid.
REQ-023 Diff, Bout and Ovf SHALL remain stable while out_valid && !out_ready.
REQ-024 Throughput SHALL be one result per cycle when out_ready is held high.
REQ-025 Bubbles (in_valid=0) SHALL propagate as valid=0 stages, and results SHALL retain acceptance order with no loss or duplication.
REQ-026 Simultaneous accept and output transfer in the same cycle SHALL both complete.
REQ-027 When out_valid=0, the Diff/Bout/Ovf values are don't-care but SHALL be deterministic (no X after reset).

Reset
REQ-028 rst=1 at a clock edge SHALL clear all four stage valid bits; out_valid=0, Diff=0, Bout=0, Ovf=0 after that edge.
REQ-029 While rst=1, in_ready SHALL be 0, and inputs SHALL be ignored.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight results; no result from before reset SHALL appear after reset.
REQ-031 in_ready=1 SHALL hold on the first cycle after rst deasserts.

Verification
REQ-032 A=5, B=3, Bin=0, out_ready=1 -> 4 cycles later Diff=0x00000002, Bout=0, Ovf=0.
REQ-033 A=0, B=1, Bin=0 -> Diff=0xFFFFFFFF, Bout=1, Ovf=0; separately A=0, B=0, Bin=1 -> Diff=0xFFFFFFFF, Bout=1, Ovf=0.
REQ-034 Overflow and borrow corners:
- A=0x80000000, B=0x00000001 -> Diff=0x7FFFFFFF, Ovf=1, Bout=0.
- A=0x7FFFFFFF, B=0xFFFFFFFF -> Diff=0x80000000, Ovf=1, Bout=1.
REQ-035 Backpressure:
- Stimulus: stream 6 back-to-back sets, A=i+10, B=i (i=0..5), with out_ready low for cycles 5-7.
- Response: in_ready low exactly during the stall; all six results are Diff=10, in order, with no loss or duplication; Diff is held stable during the stall.
REQ-036 Reset mid-operation:
- Stimulus: assert rst for 1 cycle with 3 results in flight.
- Response: out_valid=0 next cycle; no stale result ever emerges; a set accepted afterwards yields a correct result 4 cycles later.
REQ-037 Random check: 10k random A/B/Bin with random in_valid/out_ready -> every output matches the reference model (A - B - Bin, Bout, Ovf), in order.
